// File: rtl/stage_mem_pkg.sv
// Shared definitions for the MEM stage: opcodes, funct3 codes, FSM states and byte-count helpers.
package stage_mem_pkg;

  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] STORE_OP = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Index of the last byte of an access (byte count minus one).
  localparam logic [1:0] LAST_B = 2'd0;
  localparam logic [1:0] LAST_H = 2'd1;
  localparam logic [1:0] LAST_W = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_XFER = 3'd2,
    S_TAIL = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic [1:0] last_idx(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return LAST_B;
      2'b01:   return LAST_H;
      default: return LAST_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign- or zero-extends the assembled little-endian load buffer according to funct3.
module mem_load_ext
  import stage_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] w;
    w = v;
    return w;
  endfunction

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] w;
    w = v;
    return w;
  endfunction

  always_comb begin
    case (funct3)
      F3_LB:   ext = sext8(raw[7:0]);
      F3_LH:   ext = sext16(raw[15:0]);
      F3_LBU:  ext = {24'd0, raw[7:0]};
      F3_LHU:  ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// RV32I memory-access stage: byte-serial loads/stores over a shared 8-bit RAM port.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_din_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              stall_req_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_o
`endif
);

  state_e      state, state_nxt;
  logic [1:0]  k;
  logic        cap_pend;
  logic [1:0]  cap_lane;
  logic [31:0] lbuf;
  logic [31:0] ext_data;
  logic [31:0] byte_addr;
  logic        is_load, is_store, is_mem, last_byte, misalign;

  assign is_load   = (opcode_i == LOAD_OP);
  assign is_store  = (opcode_i == STORE_OP);
  assign is_mem    = is_load || is_store;
  assign last_byte = (k == last_idx(funct3_i));
  assign byte_addr = mem_addr_i + {30'd0, k};

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign   = is_mem && ((funct3_i[1:0] == 2'b01 && mem_addr_i[0]) ||
                                 (funct3_i[1:0] == 2'b10 && mem_addr_i[1:0] != 2'b00));
  assign misalign_o = rst && (state == S_DONE) && misalign;
`else
  assign misalign = 1'b0;
`endif

  mem_load_ext u_ext (
    .funct3 (funct3_i),
    .raw    (lbuf),
    .ext    (ext_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= S_IDLE;
    else if (rdy) state <= state_nxt;
  end

  // An immediate grant in IDLE goes straight to XFER; REQ only absorbs grant wait cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (is_mem) begin
        if (misalign)       state_nxt = S_DONE;
        else if (mem_gnt_i) state_nxt = S_XFER;
        else                state_nxt = S_REQ;
      end
      S_REQ:  if (mem_gnt_i) state_nxt = S_XFER;
      S_XFER: if (last_byte) state_nxt = is_store ? S_DONE : S_TAIL;
      S_TAIL: state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The read byte is only valid in the cycle after its address, so a pending
  // capture completes even if rdy drops in that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= 2'd0;
      cap_pend <= 1'b0;
      cap_lane <= 2'd0;
      lbuf     <= 32'd0;
    end else begin
      if (cap_pend) lbuf[{cap_lane, 3'b000} +: 8] <= mem_din_i;
      cap_pend <= rdy && (state == S_XFER) && is_load;
      if (rdy) begin
        cap_lane <= k;
        k        <= (state == S_XFER) ? k + 2'd1 : 2'd0;
      end
    end
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_wr_o    = 1'b0;
    mem_a_o     = '0;
    mem_dout_o  = 8'd0;
    stall_req_o = is_mem && (state != S_DONE);
    wd_o        = wd_i;
    wreg_o      = wreg_i && !stall_req_o;
    wdata_o     = wdata_i;
    case (state)
      S_IDLE: mem_req_o = is_mem && !misalign;
      S_REQ:  mem_req_o = 1'b1;
      S_XFER: begin
        mem_req_o = 1'b1;
        mem_a_o   = ADDR_W'(byte_addr);
        if (is_store) begin
          mem_dout_o = wdata_i[{k, 3'b000} +: 8];
          mem_wr_o   = rdy;
        end
      end
      S_TAIL: mem_req_o = 1'b1;
      S_DONE: begin
        if (misalign || is_store) wreg_o  = 1'b0;
        else if (is_load)         wdata_o = ext_data;
      end
      default: ;
    endcase
    if (!rst) begin
      mem_req_o   = 1'b0;
      mem_wr_o    = 1'b0;
      mem_a_o     = '0;
      mem_dout_o  = 8'd0;
      stall_req_o = 1'b0;
      wd_o        = 5'd0;
      wreg_o      = 1'b0;
      wdata_o     = 32'd0;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Randomized self-checking bench for stage_mem against a byte-array memory model.
module tb_stage_mem;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_ADD = 7'b0110011;

  logic        clk, rst, rdy;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] mem_addr_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, mem_gnt_i;
  logic [7:0]  mem_din_i;
  logic        mem_req_o, mem_wr_o, stall_req_o, wreg_o;
  logic [31:0] mem_a_o, wdata_o;
  logic [7:0]  mem_dout_o;
  logic [4:0]  wd_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  logic [7:0]  ram     [65536];
  logic [7:0]  ref_mem [65536];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] g_wdata = 32'd0;
  int          g_held  = 0;

  stage_mem #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .opcode_i    (opcode_i),
    .funct3_i    (funct3_i),
    .mem_addr_i  (mem_addr_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .mem_gnt_i   (mem_gnt_i),
    .mem_din_i   (mem_din_i),
    .mem_req_o   (mem_req_o),
    .mem_a_o     (mem_a_o),
    .mem_dout_o  (mem_dout_o),
    .mem_wr_o    (mem_wr_o),
    .stall_req_o (stall_req_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_o  (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port byte RAM with one-cycle read latency.
  initial begin
    mem_din_i = 8'd0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
    forever begin
      @(posedge clk);
      mem_din_i <= ram[mem_a_o[15:0]];
      if (mem_wr_o) ram[mem_a_o[15:0]] = mem_dout_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"},   {28'd0, mem_req_o, mem_wr_o, stall_req_o, wreg_o}, 32'd0);
    chk({tag, "_addr"},  mem_a_o, 32'd0);
    chk({tag, "_wdata"}, wdata_o, 32'd0);
    chk({tag, "_misc"},  {19'd0, wd_o, mem_dout_o}, 32'd0);
  endtask

  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] data, input int gdel, input int rlen_in, input int rofs);
    int          nb, held, wrs, reqs, rdrop, rlen, exp_held;
    bit          ld, st, mis, done;
    longint      raw;
    logic [15:0] ix;
    logic [31:0] exp_data;
    logic [4:0]  wd;
    logic        wr;
    ld   = (op == OP_LD);
    st   = (op == OP_ST);
    nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    mis  = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis  = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
`endif
    rlen = mis ? 0 : rlen_in;
    rdrop = gdel + 1 + (rofs % nb);
    raw = 0;
    for (int i = 0; i < nb; i++) begin
      ix  = addr[15:0] + 16'(i);
      raw = raw + (longint'(ref_mem[ix]) << (8 * i));
    end
    if (!f3[2] && nb < 4 && raw >= (longint'(1) << (8 * nb - 1)))
      raw = raw - (longint'(1) << (8 * nb));
    exp_data = raw[31:0];
    wd = 5'($urandom);
    wr = 1'($urandom);
    opcode_i = op; funct3_i = f3; mem_addr_i = addr; wdata_i = data; wd_i = wd; wreg_i = wr;
    held = 0; wrs = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      mem_gnt_i = (c >= gdel);
      rdy = !(c >= rdrop && c < rdrop + rlen);
      @(negedge clk);
      if (mem_wr_o) wrs++;
      if (mem_req_o) reqs++;
      if (stall_req_o) begin
        if (c > 0) held++;
      end else begin
        done    = 1'b1;
        g_wdata = wdata_o;
        chk("wd", 32'(wd_o), 32'(wd));
        chk("wreg", 32'(wreg_o), 32'(ld && !mis && wr));
        if (ld && !mis) chk("ld_data", wdata_o, exp_data);
`ifdef MEM_ALIGN_CHECK_EN
        chk("misalign", 32'(misalign_o), 32'(mis));
`endif
      end
      @(posedge clk); #1;
    end
    rdy = 1'b1;
    g_held = held;
    chk("done_seen", 32'(done), 32'd1);
    exp_held = mis ? 0 : nb + (ld ? 1 : 0) + gdel + rlen;
    chk("held", 32'(held), 32'(exp_held));
    chk("wr_cnt", 32'(wrs), 32'((st && !mis) ? nb : 0));
    if (mis) chk("req_cnt", 32'(reqs), 32'd0);
    if (st && !mis) begin
      for (int i = 0; i < nb; i++) begin
        ix = addr[15:0] + 16'(i);
        ref_mem[ix] = data[8 * i +: 8];
        chk("st_byte", 32'(ram[ix]), 32'(ref_mem[ix]));
      end
    end
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] f3;
    bit         is_ld;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
    rst = 1'b0; rdy = 1'b1; mem_gnt_i = 1'b0;
    opcode_i = OP_ADD; funct3_i = 3'd0; mem_addr_i = 32'd0; wdata_i = 32'hDEAD_BEEF;
    wd_i = 5'd7; wreg_i = 1'b1;
    #12;
    chk_zero("por");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    do_op(OP_ST, 3'b010, 32'h0000_1000, 32'h1234_5678, 0, 0, 0);
    do_op(OP_LD, 3'b010, 32'h0000_1000, 32'h0, 0, 0, 0);
    chk("lw_val", g_wdata, 32'h1234_5678);
    chk("lw_held", 32'(g_held), 32'd5);

    do_op(OP_ST, 3'b000, 32'h0000_1010, 32'h0000_0080, 0, 0, 0);
    do_op(OP_LD, 3'b000, 32'h0000_1010, 32'h0, 0, 0, 0);
    chk("lb_val", g_wdata, 32'hFFFF_FF80);
    do_op(OP_LD, 3'b100, 32'h0000_1010, 32'h0, 0, 0, 0);
    chk("lbu_val", g_wdata, 32'h0000_0080);

    do_op(OP_ST, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 0, 0);
    chk("sh_lo", 32'(ram[16'h2002]), 32'h0000_00EF);
    chk("sh_hi", 32'(ram[16'h2003]), 32'h0000_00BE);

    do_op(OP_ST, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 3, 0, 0);
    chk("sw_gnt_held", 32'(g_held), 32'd7);
    do_op(OP_ST, 3'b010, 32'h0000_3004, 32'h0123_4567, 0, 2, 1);
    chk("sw_rdy_held", 32'(g_held), 32'd6);

`ifdef MEM_ALIGN_CHECK_EN
    do_op(OP_LD, 3'b010, 32'h0000_1001, 32'h0, 0, 0, 0);
    chk("mis_held", 32'(g_held), 32'd0);
`endif

    for (int n = 0; n < 60; n++) begin
      is_ld = 1'($urandom);
      f3 = is_ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      do_op(is_ld ? OP_LD : OP_ST, f3, 32'($urandom_range(0, 16'h7FFF)), $urandom,
            int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a word store, then a pass-through ALU op.
    opcode_i = OP_ST; funct3_i = 3'b010; mem_addr_i = 32'h0000_9000; wdata_i = $urandom;
    mem_gnt_i = 1'b1; rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1 chk_zero("rst_xfer");
    opcode_i = OP_ADD;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    wd_i = 5'd19; wreg_i = 1'b1; wdata_i = 32'h0BAD_F00D;
    @(negedge clk);
    chk("add_stall", 32'(stall_req_o), 32'd0);
    chk("add_req", 32'(mem_req_o), 32'd0);
    chk("add_wd", 32'(wd_o), 32'd19);
    chk("add_wreg", 32'(wreg_o), 32'd1);
    chk("add_wdata", wdata_o, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
